// File: rtl/frame_tick_writer.sv
// frame_tick_writer: per-frame game-state sequencer in front of the sprite/score
// display block. On each accepted vertical-sync tick it scrolls the cactus X
// position and advances the score. It then writes both values to the display
// block's register bus. CPU writes share that bus at lower priority.
//
// Build option: define FRAME_TICK_SCORE_EN to include the frame counter, the score
// digit and the score register write. Without it, score is tied to 0 and only the
// cactus write is issued each frame.
//
// Bus timing for an accepted tick in cycle T:
//   T   : status registers and the cactus write are loaded. Non-CTRL CPU writes
//         are stalled.
//   T+1 : the cactus write is on disp_* (state WR_CAC). With the score enabled,
//         the score write is loaded and the CPU is still stalled.
//   T+2 : the score write is on disp_* (state WR_SCORE). Arbitration is already
//         open again, so a CPU write accepted here appears at T+3.
`timescale 1ns/1ps

module frame_tick_writer #(
    parameter int         SPEED            = 2,
    parameter logic [7:0] CAC_START        = 8'd250,
    parameter int         FRAMES_PER_POINT = 60,
    parameter logic [8:0] CTRL_ADDR        = 9'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_vs_n,
    input  logic        cpu_chipselect,
    input  logic        cpu_write,
    input  logic [8:0]  cpu_address,
    input  logic [31:0] cpu_writedata,
    output logic        cpu_waitrequest,
    output logic        disp_chipselect,
    output logic        disp_write,
    output logic [8:0]  disp_address,
    output logic [31:0] disp_writedata,
    output logic [7:0]  cac_x,
    output logic [3:0]  score
);

    localparam logic [7:0] SPEED_B    = 8'(SPEED);
    localparam logic [8:0] ADDR_CAC   = 9'd6;
    localparam logic [8:0] ADDR_SCORE = 9'd10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_CAC   = 2'd1,
        WR_SCORE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_vs_meta;
    logic        r_vs_sync;
    logic        r_vs_prev;
    logic        r_run;
    logic [7:0]  r_cac;
    logic        r_disp_cs;
    logic        r_disp_wr;
    logic [8:0]  r_disp_addr;
    logic [31:0] r_disp_data;

    logic        w_tick;
    logic        w_busy;
    logic        w_tick_ok;
    logic        w_cpu_req;
    logic        w_is_ctrl;
    logic        w_ctrl_wr;
    logic        w_clear;
    logic        w_fwd;
    logic [7:0]  w_cac_next;
    logic        w_unused_bits;

    // vsync comes from another timing domain: two flops, then one history flop for edge detect.
    // Reset to the inactive (high) level so that leaving reset never creates a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_meta <= 1'b1;
            r_vs_sync <= 1'b1;
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_meta <= vga_vs_n;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_tick = r_vs_prev & ~r_vs_sync;

`ifdef FRAME_TICK_SCORE_EN
    // With the score enabled, the cycle spent loading the score write keeps the bus.
    assign w_busy = (r_state == WR_CAC);
`else
    assign w_busy = 1'b0;
`endif

    assign w_cpu_req = cpu_chipselect & cpu_write;
    assign w_is_ctrl = (cpu_address == CTRL_ADDR);
    assign w_ctrl_wr = w_cpu_req & w_is_ctrl;
    assign w_clear   = w_ctrl_wr & cpu_writedata[1];
    assign w_tick_ok = w_tick & r_run & ~w_busy;

    // Control writes are handled locally, so they are never stalled.
    assign cpu_waitrequest = w_cpu_req & ~w_is_ctrl & (w_busy | w_tick_ok);
    assign w_fwd           = w_cpu_req & ~w_is_ctrl & ~cpu_waitrequest;

    // Only bits 1:0 of the control word carry meaning.
    assign w_unused_bits = ^cpu_writedata[31:2];

    // Next cactus position: clear has priority over the scroll; the reload avoids underflow.
    always_comb begin
        w_cac_next = r_cac;
        if (w_clear) begin
            w_cac_next = CAC_START;
        end else if (w_tick_ok) begin
            if (r_cac < SPEED_B) begin
                w_cac_next = CAC_START;
            end else begin
                w_cac_next = r_cac - SPEED_B;
            end
        end else begin
            w_cac_next = r_cac;
        end
    end

    // Run flag from the control register; clear is a pulse and is not stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_run <= cpu_writedata[0];
        end else begin
            r_run <= r_run;
        end
    end

    // Cactus status register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cac <= CAC_START;
        end else begin
            r_cac <= w_cac_next;
        end
    end

`ifdef FRAME_TICK_SCORE_EN
    localparam int CNT_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_POINT - 1);

    logic [CNT_W-1:0] r_frame_cnt;
    logic [3:0]       r_score;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       w_score_next;

    // Frame counter and decimal score digit: clear wins, otherwise advance on an accepted tick.
    always_comb begin
        w_cnt_next   = r_frame_cnt;
        w_score_next = r_score;
        if (w_clear) begin
            w_cnt_next   = {CNT_W{1'b0}};
            w_score_next = 4'd0;
        end else if (w_tick_ok) begin
            if (r_frame_cnt == CNT_LAST) begin
                w_cnt_next   = {CNT_W{1'b0}};
                w_score_next = (r_score == 4'd9) ? 4'd0 : (r_score + 4'd1);
            end else begin
                w_cnt_next   = r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                w_score_next = r_score;
            end
        end else begin
            w_cnt_next   = r_frame_cnt;
            w_score_next = r_score;
        end
    end

    // Frame counter and score status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= {CNT_W{1'b0}};
            r_score     <= 4'd0;
        end else begin
            r_frame_cnt <= w_cnt_next;
            r_score     <= w_score_next;
        end
    end

    assign score = r_score;
`else
    assign score = 4'd0;
`endif

    // Write sequencer: the state names the write currently held on the registered disp_* outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_disp_cs   <= 1'b0;
            r_disp_wr   <= 1'b0;
            r_disp_addr <= 9'd0;
            r_disp_data <= 32'd0;
        end else if (w_tick_ok) begin
            r_state     <= WR_CAC;
            r_disp_cs   <= 1'b1;
            r_disp_wr   <= 1'b1;
            r_disp_addr <= ADDR_CAC;
            r_disp_data <= {24'd0, w_cac_next};
        end else if (w_busy) begin
`ifdef FRAME_TICK_SCORE_EN
            r_state     <= WR_SCORE;
            r_disp_cs   <= 1'b1;
            r_disp_wr   <= 1'b1;
            r_disp_addr <= ADDR_SCORE;
            r_disp_data <= {28'd0, r_score};
`else
            r_state     <= IDLE;
            r_disp_cs   <= 1'b0;
            r_disp_wr   <= 1'b0;
            r_disp_addr <= 9'd0;
            r_disp_data <= 32'd0;
`endif
        end else if (w_fwd) begin
            r_state     <= IDLE;
            r_disp_cs   <= 1'b1;
            r_disp_wr   <= 1'b1;
            r_disp_addr <= cpu_address;
            r_disp_data <= cpu_writedata;
        end else begin
            r_state     <= IDLE;
            r_disp_cs   <= 1'b0;
            r_disp_wr   <= 1'b0;
            r_disp_addr <= 9'd0;
            r_disp_data <= 32'd0;
        end
    end

    assign disp_chipselect = r_disp_cs;
    assign disp_write      = r_disp_wr;
    assign disp_address    = r_disp_addr;
    assign disp_writedata  = r_disp_data;
    assign cac_x           = r_cac;

endmodule

// File: tb/tb_frame_tick_writer.sv
// Directed testbench for frame_tick_writer (SPEED=2, CAC_START=250,
// FRAMES_PER_POINT=3, CTRL_ADDR=16). Follows FRAME_TICK_SCORE_EN like the design.
`timescale 1ns/1ps

module tb_frame_tick_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_vs_n;
    logic        cpu_chipselect;
    logic        cpu_write;
    logic [8:0]  cpu_address;
    logic [31:0] cpu_writedata;
    logic        cpu_waitrequest;
    logic        disp_chipselect;
    logic        disp_write;
    logic [8:0]  disp_address;
    logic [31:0] disp_writedata;
    logic [7:0]  cac_x;
    logic [3:0]  score;

    int errors = 0;
    int checks = 0;

    // reference model of the game state
    int m_cac   = 250;
    int m_cnt   = 0;
    int m_score = 0;
    int m_run   = 0;

    frame_tick_writer #(
        .SPEED(2), .CAC_START(8'd250), .FRAMES_PER_POINT(3), .CTRL_ADDR(9'd16)
    ) dut (
        .clk(clk), .reset(reset), .vga_vs_n(vga_vs_n),
        .cpu_chipselect(cpu_chipselect), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
        .cpu_waitrequest(cpu_waitrequest),
        .disp_chipselect(disp_chipselect), .disp_write(disp_write),
        .disp_address(disp_address), .disp_writedata(disp_writedata),
        .cac_x(cac_x), .score(score)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_chipselect = 1'b0;
        cpu_write      = 1'b0;
        cpu_address    = 9'd0;
        cpu_writedata  = 32'd0;
    endtask

    task automatic model_tick();
        if (m_run != 0) begin
            m_cac = (m_cac < 2) ? 250 : m_cac - 2;
`ifdef FRAME_TICK_SCORE_EN
            if (m_cnt == 2) begin
                m_cnt   = 0;
                m_score = (m_score == 9) ? 0 : m_score + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
`endif
        end
    endtask

    // Vsync falling edge; returns in the cycle where the tick is active.
    task automatic frame_tick();
        vga_vs_n = 1'b0;
        step();
        step();
        vga_vs_n = 1'b1;
        model_tick();
    endtask

    task automatic ctrl_write(input logic [31:0] data);
        cpu_chipselect = 1'b1; cpu_write = 1'b1; cpu_address = 9'd16; cpu_writedata = data;
        #1;
        checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL ctrl_wait: got %0b want 0", cpu_waitrequest); end
        step();
        cpu_idle();
        checks++; if (disp_write !== 1'b0) begin errors++; $display("FAIL ctrl_not_fwd: disp_write got %0b want 0", disp_write); end
        m_run = int'(data[0]);
        if (data[1]) begin m_cac = 250; m_cnt = 0; m_score = 0; end
    endtask

    // One full frame with the bus writes checked against the model.
    task automatic run_frame();
        frame_tick();
        step();
        checks++;
        if (disp_write !== 1'b1 || disp_chipselect !== 1'b1 || disp_address !== 9'd6 || disp_writedata !== 32'(m_cac) || cac_x !== 8'(m_cac)) begin
            errors++;
            $display("FAIL frame_cac: wr=%0b addr=%0d data=%0d cac_x=%0d want addr=6 data=%0d", disp_write, disp_address, disp_writedata, cac_x, m_cac);
        end
        step();
        checks++;
`ifdef FRAME_TICK_SCORE_EN
        if (disp_write !== 1'b1 || disp_address !== 9'd10 || disp_writedata !== 32'(m_score) || score !== 4'(m_score)) begin
            errors++;
            $display("FAIL frame_score: wr=%0b addr=%0d data=%0d score=%0d want addr=10 data=%0d", disp_write, disp_address, disp_writedata, score, m_score);
        end
`else
        if (disp_write !== 1'b0 || score !== 4'd0) begin
            errors++;
            $display("FAIL frame_noscore: wr=%0b score=%0d want wr=0 score=0", disp_write, score);
        end
`endif
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; vga_vs_n = 1'b1; cpu_idle();
        step(); step();
        checks++; if (disp_write !== 1'b0 || disp_chipselect !== 1'b0) begin errors++; $display("FAIL reset_disp_ctl: wr=%0b cs=%0b want 0", disp_write, disp_chipselect); end
        checks++; if (disp_address !== 9'd0 || disp_writedata !== 32'd0) begin errors++; $display("FAIL reset_disp_bus: addr=%0d data=%0d want 0", disp_address, disp_writedata); end
        checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait: got %0b want 0", cpu_waitrequest); end
        checks++; if (cac_x !== 8'd250) begin errors++; $display("FAIL reset_cac: got %0d want 250", cac_x); end
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_first_frame();
        ctrl_write(32'd1);
        frame_tick();
        checks++; if (disp_write !== 1'b0) begin errors++; $display("FAIL first_T: disp_write got %0b want 0", disp_write); end
        step();
        checks++; if (disp_write !== 1'b1 || disp_address !== 9'd6 || disp_writedata !== 32'd248) begin errors++; $display("FAIL first_cac: wr=%0b addr=%0d data=%0d want 1/6/248", disp_write, disp_address, disp_writedata); end
        checks++; if (cac_x !== 8'd248) begin errors++; $display("FAIL first_cac_x: got %0d want 248", cac_x); end
        step();
`ifdef FRAME_TICK_SCORE_EN
        checks++; if (disp_write !== 1'b1 || disp_address !== 9'd10 || disp_writedata !== 32'd0) begin errors++; $display("FAIL first_score: wr=%0b addr=%0d data=%0d want 1/10/0", disp_write, disp_address, disp_writedata); end
`else
        checks++; if (disp_write !== 1'b0) begin errors++; $display("FAIL first_noscore: wr=%0b want 0", disp_write); end
`endif
        step();
        checks++; if (disp_write !== 1'b0) begin errors++; $display("FAIL first_end: wr=%0b want 0", disp_write); end
    endtask

    task automatic test_score_seq();
        for (int i = 0; i < 30; i++) begin
            run_frame();
`ifdef FRAME_TICK_SCORE_EN
            if (i == 25) begin
                checks++; if (score !== 4'd9) begin errors++; $display("FAIL score_at_27: got %0d want 9", score); end
            end
`endif
        end
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL score_after_31: got %0d want 0", score); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 200 && m_cac != 0; i++) begin
            run_frame();
        end
        checks++; if (cac_x !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", cac_x); end
        run_frame();
        checks++; if (cac_x !== 8'd250) begin errors++; $display("FAIL wrap_reload: got %0d want 250", cac_x); end
    endtask

    task automatic test_passthrough();
        cpu_chipselect = 1'b1; cpu_write = 1'b1; cpu_address = 9'd10; cpu_writedata = 32'd7;
        #1;
        checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL pass_wait: got %0b want 0", cpu_waitrequest); end
        step();
        cpu_idle();
        checks++; if (disp_write !== 1'b1 || disp_chipselect !== 1'b1 || disp_address !== 9'd10 || disp_writedata !== 32'd7) begin errors++; $display("FAIL pass_fwd: wr=%0b addr=%0d data=%0d want 1/10/7", disp_write, disp_address, disp_writedata); end
        step();
        checks++; if (disp_write !== 1'b0) begin errors++; $display("FAIL pass_once: wr=%0b want 0", disp_write); end
    endtask

    task automatic test_cpu_in_tick();
        frame_tick();
        cpu_chipselect = 1'b1; cpu_write = 1'b1; cpu_address = 9'd2; cpu_writedata = 32'h55;
        #1;
        checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_wait_T: got %0b want 1", cpu_waitrequest); end
        step();
        checks++; if (disp_address !== 9'd6 || disp_writedata !== 32'(m_cac)) begin errors++; $display("FAIL cpu_cac: addr=%0d data=%0d want 6/%0d", disp_address, disp_writedata, m_cac); end
`ifdef FRAME_TICK_SCORE_EN
        checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_wait_T1: got %0b want 1", cpu_waitrequest); end
        step();
        checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpu_wait_T2: got %0b want 0", cpu_waitrequest); end
        checks++; if (disp_address !== 9'd10 || disp_writedata !== 32'(m_score)) begin errors++; $display("FAIL cpu_score: addr=%0d data=%0d want 10/%0d", disp_address, disp_writedata, m_score); end
`else
        checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpu_wait_T1: got %0b want 0", cpu_waitrequest); end
`endif
        step();
        cpu_idle();
        checks++; if (disp_write !== 1'b1 || disp_address !== 9'd2 || disp_writedata !== 32'h55) begin errors++; $display("FAIL cpu_fwd: wr=%0b addr=%0d data=%0h want 1/2/55", disp_write, disp_address, disp_writedata); end
        step();
        checks++; if (disp_write !== 1'b0) begin errors++; $display("FAIL cpu_once: wr=%0b want 0", disp_write); end
    endtask

    task automatic test_clear_in_tick();
        frame_tick();
        cpu_chipselect = 1'b1; cpu_write = 1'b1; cpu_address = 9'd16; cpu_writedata = 32'd3;
        #1;
        checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL clr_wait: got %0b want 0", cpu_waitrequest); end
        m_cac = 250; m_cnt = 0; m_score = 0; m_run = 1;
        step();
        cpu_idle();
        checks++; if (disp_write !== 1'b1 || disp_address !== 9'd6 || disp_writedata !== 32'd250 || cac_x !== 8'd250) begin errors++; $display("FAIL clr_cac: wr=%0b addr=%0d data=%0d cac_x=%0d want 1/6/250/250", disp_write, disp_address, disp_writedata, cac_x); end
        step();
`ifdef FRAME_TICK_SCORE_EN
        checks++; if (disp_write !== 1'b1 || disp_address !== 9'd10 || disp_writedata !== 32'd0 || score !== 4'd0) begin errors++; $display("FAIL clr_score: wr=%0b addr=%0d data=%0d score=%0d want 1/10/0/0", disp_write, disp_address, disp_writedata, score); end
`else
        checks++; if (disp_write !== 1'b0) begin errors++; $display("FAIL clr_noscore: wr=%0b want 0", disp_write); end
`endif
        step();
        checks++; if (disp_write !== 1'b0) begin errors++; $display("FAIL clr_end: wr=%0b want 0", disp_write); end
    endtask

    task automatic test_run_off();
        logic seen;
        ctrl_write(32'd0);
        for (int v = 0; v < 5; v++) begin
            seen = 1'b0;
            frame_tick();
            for (int c = 0; c < 4; c++) begin
                seen = seen | disp_write;
                step();
            end
            checks++; if (seen !== 1'b0 || cac_x !== 8'd250) begin errors++; $display("FAIL runoff_%0d: write_seen=%0b cac_x=%0d want 0/250", v, seen, cac_x); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        ctrl_write(32'd1);
        frame_tick();
        step();
        checks++; if (disp_write !== 1'b1 || cac_x !== 8'd248) begin errors++; $display("FAIL mid_pre: wr=%0b cac_x=%0d want 1/248", disp_write, cac_x); end
        reset = 1'b1;
        #1;
        checks++; if (disp_write !== 1'b0 || disp_chipselect !== 1'b0) begin errors++; $display("FAIL mid_disp: wr=%0b cs=%0b want 0", disp_write, disp_chipselect); end
        checks++; if (cac_x !== 8'd250 || score !== 4'd0) begin errors++; $display("FAIL mid_status: cac_x=%0d score=%0d want 250/0", cac_x, score); end
        step();
        reset = 1'b0;
        m_cac = 250; m_cnt = 0; m_score = 0; m_run = 0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            seen = seen | disp_write;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_score: write_seen=%0b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_score_seq();
        test_wrap();
        test_passthrough();
        test_cpu_in_tick();
        test_clear_in_tick();
        test_run_off();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
